// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the initial-program loader: FSM state encoding,
// host command codes and response bytes.
// Also provides the default text memory address width when the including
// build does not supply one.
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 13
`endif

package loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_LO,
        S_ADDR_HI,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA0,
        S_DATA1,
        S_DATA2,
        S_CSUM,
        S_RESP
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

endpackage

// File: rtl/text_loader.sv
// -----------------------------------------------------------------------------
// text_loader
// Write-side master for the CPU instruction memory. Parses framed bytes from
// the host link, assembles 18-bit words {b2[1:0], b1, b0} and writes them to
// consecutive text memory addresses, holds the CPU in reset while loading and
// answers every frame with one ACK/NAK byte.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   rx_data/valid/ready    inbound byte stream (transfer on valid & ready)
//   tx_data/valid/ready    response byte (transfer on valid & ready)
//   mem_addr/wr/wr_data    registered one-cycle text memory write port
//   cpu_hold               1 = keep the CPU in reset
// -----------------------------------------------------------------------------
module text_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = `ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr,
    output logic [17:0]           mem_wr_data,
    output logic                  cpu_hold
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                state, state_next;
    logic                  rx_ready_q;
    logic                  accept;
    logic [7:0]            lo_q;        // low byte of address or count
    logic [7:0]            b0_q, b1_q;
    logic [7:0]            csum_q;
    logic [7:0]            rsp_q, rsp_next;
    logic [15:0]           cnt_q;       // N, words in this frame
    logic [15:0]           word_cnt_q;  // k, words consumed so far
    logic [ADDR_WIDTH-1:0] wr_addr_q;   // start + k
    logic                  err_q;
    logic [TMO_W-1:0]      tmo_q;
    logic                  in_frame;
    logic                  tmo_hit;
    logic                  b2_ok;
    logic                  last_word;

    // rx_ready is registered so that it stays low throughout reset and rises
    // on the first edge after release; it always mirrors "state != RESP".
    assign rx_ready  = rx_ready_q;
    assign accept    = rx_valid & rx_ready_q;
    assign tx_valid  = (state == S_RESP);
    assign tx_data   = rsp_q;

    assign in_frame  = (state != S_IDLE) && (state != S_RESP);
    // tmo_q counts idle cycles already elapsed; the TIMEOUT_CYCLES-th idle
    // cycle is the one that fires.
    assign tmo_hit   = in_frame && !accept && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign b2_ok     = (rx_data[7:2] == 6'd0);
    assign last_word = ((word_cnt_q + 16'd1) == cnt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rsp_next   = rsp_q;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (rx_data == CMD_LOAD) begin
                        state_next = S_ADDR_LO;
                    end else if (rx_data == CMD_RUN) begin
                        state_next = S_RESP;
                        rsp_next   = RSP_ACK;
                    end else begin
                        state_next = S_RESP;
                        rsp_next   = RSP_NAK;
                    end
                end
            end
            S_ADDR_LO: if (accept) state_next = S_ADDR_HI;
            S_ADDR_HI: if (accept) state_next = S_CNT_LO;
            S_CNT_LO:  if (accept) state_next = S_CNT_HI;
            S_CNT_HI: begin
                if (accept) begin
                    state_next = ({rx_data, lo_q} != 16'd0) ? S_DATA0 : S_CSUM;
                end
            end
            S_DATA0:   if (accept) state_next = S_DATA1;
            S_DATA1:   if (accept) state_next = S_DATA2;
            S_DATA2: begin
                if (accept) begin
                    state_next = last_word ? S_CSUM : S_DATA0;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_next = S_RESP;
                    rsp_next   = ((rx_data == csum_q) && !err_q) ? RSP_ACK : RSP_NAK;
                end
            end
            S_RESP: begin
                if (tx_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (tmo_hit) begin
            state_next = S_RESP;
            rsp_next   = RSP_NAK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready_q  <= 1'b0;
            rsp_q       <= 8'h00;
            lo_q        <= 8'h00;
            b0_q        <= 8'h00;
            b1_q        <= 8'h00;
            csum_q      <= 8'h00;
            cnt_q       <= 16'd0;
            word_cnt_q  <= 16'd0;
            wr_addr_q   <= '0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= 18'd0;
            cpu_hold    <= 1'b1;
        end else begin
            rx_ready_q <= (state_next != S_RESP);
            rsp_q      <= rsp_next;
            mem_wr     <= 1'b0;

            if (!in_frame || accept) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TMO_W'(1);
            end

            if (accept) begin
                // Checksum covers every byte after the command byte; the
                // value added while in CSUM is never used.
                if (state == S_IDLE) begin
                    csum_q <= 8'h00;
                end else begin
                    csum_q <= csum_q + rx_data;
                end

                case (state)
                    S_IDLE: begin
                        err_q      <= 1'b0;
                        word_cnt_q <= 16'd0;
                        if (rx_data == CMD_LOAD) cpu_hold <= 1'b1;
                        if (rx_data == CMD_RUN)  cpu_hold <= 1'b0;
                    end
                    S_ADDR_LO: lo_q      <= rx_data;
                    S_ADDR_HI: wr_addr_q <= ADDR_WIDTH'({rx_data, lo_q});
                    S_CNT_LO:  lo_q      <= rx_data;
                    S_CNT_HI:  cnt_q     <= {rx_data, lo_q};
                    S_DATA0:   b0_q      <= rx_data;
                    S_DATA1:   b1_q      <= rx_data;
                    S_DATA2: begin
                        // A malformed word still consumes its address slot.
                        if (b2_ok) begin
                            mem_wr      <= 1'b1;
                            mem_addr    <= wr_addr_q;
                            mem_wr_data <= {rx_data[1:0], b1_q, b0_q};
                        end else begin
                            err_q <= 1'b1;
                        end
                        wr_addr_q  <= wr_addr_q + ADDR_WIDTH'(1);
                        word_cnt_q <= word_cnt_q + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_text_loader.sv
module tb_text_loader;

    localparam int AW  = 13;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_wr;
    logic [17:0]   mem_wr_data;
    logic          cpu_hold;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int wr_base;

    always #5 clk = ~clk;

    text_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .mem_addr    (mem_addr),
        .mem_wr      (mem_wr),
        .mem_wr_data (mem_wr_data),
        .cpu_hold    (cpu_hold)
    );

    always @(negedge clk) if (mem_wr === 1'b1) wr_count++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge; returns #1 after the edge that took the byte.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("rx_ready_wait", 32'(rx_ready), 32'd1);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic exp_wr, input logic [31:0] exp_addr, input logic [31:0] exp_data,
                        input string tag);
        send(b0);
        send(b1);
        send(b2);
        chk({tag, "_wr"}, 32'(mem_wr), 32'(exp_wr));
        if (exp_wr) begin
            chk({tag, "_addr"}, 32'(mem_addr), exp_addr);
            chk({tag, "_data"}, 32'(mem_wr_data), exp_data);
        end
    endtask

    task automatic resp(input logic [7:0] exp, input string tag);
        int n;
        n = 0;
        while (tx_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_txv"}, 32'(tx_valid), 32'd1);
        chk({tag, "_txd"}, 32'(tx_data), 32'(exp));
        chk({tag, "_rxr_low"}, 32'(rx_ready), 32'd0);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        chk({tag, "_txv_clr"}, 32'(tx_valid), 32'd0);
        chk({tag, "_rxr_back"}, 32'(rx_ready), 32'd1);
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_wr", 32'(mem_wr), 32'd0);
        chk("rst_txv", 32'(tx_valid), 32'd0);
        chk("rst_txd", 32'(tx_data), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wr_data), 32'd0);
        chk("rst_rxr", 32'(rx_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_rxr", 32'(rx_ready), 32'd1);

        // Run: hold drops in the same cycle the ACK appears
        send(8'h02);
        chk("run_hold", 32'(cpu_hold), 32'd0);
        chk("run_txv_same", 32'(tx_valid), 32'd1);
        resp(8'h06, "run");

        // Load two words at 0x010; checksum is 0x5A
        send(8'h01);
        chk("load_hold", 32'(cpu_hold), 32'd1);
        send(8'h10); send(8'h00); send(8'h02); send(8'h00);
        word(8'h34, 8'h12, 8'h03, 1'b1, 32'h010, 32'h31234, "a_w0");
        word(8'hFF, 8'h00, 8'h00, 1'b1, 32'h011, 32'h000FF, "a_w1");
        send(8'h5A);
        chk("a_wr_one_cycle", 32'(mem_wr), 32'd0);
        resp(8'h06, "a");

        // Start 0x1FFF wraps to 0x0000; checksum 0x23
        send(8'h01); send(8'hFF); send(8'h1F); send(8'h02); send(8'h00);
        word(8'h01, 8'h00, 8'h00, 1'b1, 32'h1FFF, 32'h00001, "wrap_w0");
        word(8'h02, 8'h00, 8'h00, 1'b1, 32'h0000, 32'h00002, "wrap_w1");
        send(8'h23);
        resp(8'h06, "wrap");

        // Same frame with checksum off by one: writes still happen, NAK
        wr_base = wr_count;
        send(8'h01); send(8'hFF); send(8'h1F); send(8'h02); send(8'h00);
        word(8'h01, 8'h00, 8'h00, 1'b1, 32'h1FFF, 32'h00001, "bad_w0");
        word(8'h02, 8'h00, 8'h00, 1'b1, 32'h0000, 32'h00002, "bad_w1");
        send(8'h24);
        chk("bad_wrcnt", 32'(wr_count - wr_base), 32'd2);
        resp(8'h15, "badcs");

        // b2 = 0x04: word dropped, NAK even with correct checksum 0x6B
        wr_base = wr_count;
        send(8'h01); send(8'h00); send(8'h01); send(8'h01); send(8'h00);
        word(8'hAA, 8'hBB, 8'h04, 1'b0, 32'h0, 32'h0, "b2err");
        send(8'h6B);
        chk("b2err_wrcnt", 32'(wr_count - wr_base), 32'd0);
        resp(8'h15, "b2err");

        // Timeout after "01 00": fires on the 16th idle cycle
        send(8'h01); send(8'h00);
        for (int i = 0; i < TMO - 1; i++) tick();
        chk("tmo_not_yet", 32'(tx_valid), 32'd0);
        tick();
        chk("tmo_txv", 32'(tx_valid), 32'd1);
        chk("tmo_txd", 32'(tx_data), 32'h15);
        // Transmitter stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_txv", 32'(tx_valid), 32'd1);
            chk("stall_txd", 32'(tx_data), 32'h15);
            chk("stall_rxr", 32'(rx_ready), 32'd0);
        end
        resp(8'h15, "tmo");

        // Run, then an unknown command leaves the hold released
        send(8'h02);
        resp(8'h06, "run2");
        send(8'h07);
        chk("unk_hold", 32'(cpu_hold), 32'd0);
        resp(8'h15, "unk");

        // N = 0 frame: no writes, ACK
        wr_base = wr_count;
        send(8'h01); send(8'h00); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        resp(8'h06, "n0");
        chk("n0_wrcnt", 32'(wr_count - wr_base), 32'd0);

        // Reset while in DATA1 with b1 on the bus: no strobe, back to IDLE
        wr_base = wr_count;
        send(8'h01); send(8'h00); send(8'h00); send(8'h01); send(8'h00);
        send(8'h11);
        rx_data  = 8'h22;
        rx_valid = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        chk("mid_rst_wr", 32'(mem_wr), 32'd0);
        chk("mid_rst_txv", 32'(tx_valid), 32'd0);
        chk("mid_rst_rxr", 32'(rx_ready), 32'd0);
        rx_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        chk("mid_rst_wrcnt", 32'(wr_count - wr_base), 32'd0);
        send(8'h02);
        resp(8'h06, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
